// File: rtl/ascon_perm_seq.sv
// rtl/ascon_perm_seq.sv - iterative Ascon permutation, one round (Pc, Ps, Pl) per clock
// ascon_ps is the bit-sliced substitution layer shared with the rest of the cipher datapath.

module ascon_ps (
  input  logic [319:0] state_in,
  output logic [319:0] state_out
);

  logic [63:0] x0, x1, x2, x3, x4;
  logic [63:0] t0, t1, t2, t3, t4;

  always_comb begin
    x0 = state_in[319:256];
    x1 = state_in[255:192];
    x2 = state_in[191:128];
    x3 = state_in[127:64];
    x4 = state_in[63:0];

    x0 = x0 ^ x4;
    x4 = x4 ^ x3;
    x2 = x2 ^ x1;

    t0 = ~x0 & x1;
    t1 = ~x1 & x2;
    t2 = ~x2 & x3;
    t3 = ~x3 & x4;
    t4 = ~x4 & x0;

    x0 = x0 ^ t1;
    x1 = x1 ^ t2;
    x2 = x2 ^ t3;
    x3 = x3 ^ t4;
    x4 = x4 ^ t0;

    x1 = x1 ^ x0;
    x0 = x0 ^ x4;
    x3 = x3 ^ x2;
    x2 = ~x2;

    state_out = {x0, x1, x2, x3, x4};
  end

endmodule

module ascon_perm_seq #(
  parameter int ROUNDS_A = 12,
  parameter int ROUNDS_B = 6
) (
  input  logic         clock_i,
  input  logic         resetb_i,
  input  logic         start_i,
  input  logic         rounds_a_i,
  input  logic [319:0] state_i,
  output logic [319:0] state_o,
  output logic         busy_o,
  output logic         done_o
);

  typedef enum logic {IDLE, RUN} fsm_t;

  // The last round is always r = 11, so a shorter run simply starts later.
  localparam logic [3:0] FIRST_A = 4'(12 - ROUNDS_A);
  localparam logic [3:0] FIRST_B = 4'(12 - ROUNDS_B);

  fsm_t         fsm;
  logic [3:0]   round;
  logic [7:0]   rc;
  logic [319:0] sbox_in;
  logic [319:0] sbox_out;
  logic [319:0] round_out;

  function automatic logic [63:0] ror(input logic [63:0] v, input int unsigned n);
    return (v >> n) | (v << (64 - n));
  endfunction

  assign rc = {4'hF - round, round};

  always_comb begin
    sbox_in = state_o;
    sbox_in[135:128] = state_o[135:128] ^ rc;
  end

  ascon_ps u_ps (
    .state_in  (sbox_in),
    .state_out (sbox_out)
  );

  logic [63:0] s0, s1, s2, s3, s4;

  always_comb begin
    s0 = sbox_out[319:256];
    s1 = sbox_out[255:192];
    s2 = sbox_out[191:128];
    s3 = sbox_out[127:64];
    s4 = sbox_out[63:0];
    round_out = {s0 ^ ror(s0, 19) ^ ror(s0, 28),
                 s1 ^ ror(s1, 61) ^ ror(s1, 39),
                 s2 ^ ror(s2, 1)  ^ ror(s2, 6),
                 s3 ^ ror(s3, 10) ^ ror(s3, 17),
                 s4 ^ ror(s4, 7)  ^ ror(s4, 41)};
  end

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      fsm     <= IDLE;
      round   <= '0;
      state_o <= '0;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (fsm)
        IDLE: begin
          if (start_i) begin
            fsm     <= RUN;
            busy_o  <= 1'b1;
            state_o <= state_i;
            round   <= rounds_a_i ? FIRST_A : FIRST_B;
          end
        end
        RUN: begin
          state_o <= round_out;
          // Counter parks at 11 on the final round instead of wrapping.
          if (round == 4'd11) begin
            fsm    <= IDLE;
            busy_o <= 1'b0;
            done_o <= 1'b1;
          end else begin
            round <= round + 4'd1;
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/ascon_perm_seq.md
ASCON_PERM_SEQ -- requirements
Module: ascon_perm_seq

Interface
REQ-001 The block SHALL be clocked by one clock, clock_i, and reset by resetb_i, which is asynchronous and active-low.
REQ-002 Parameter ROUNDS_A, default 12, SHALL set the round count for p^a (initialisation/finalisation).
REQ-003 Parameter ROUNDS_B, default 6, SHALL set the round count for p^b (data processing).
REQ-004 Port clock_i  in  1  SHALL be the rising-edge clock.
REQ-005 Port resetb_i  in  1  SHALL be the asynchronous active-low reset.
REQ-006 Port start_i  in  1  SHALL request a permutation run and is sampled only in IDLE.
REQ-007 Port rounds_a_i  in  1  SHALL select the round count, sampled with start_i: 1 = ROUNDS_A, 0 = ROUNDS_B.
REQ-008 Port state_i  in  type_state (5x64)  SHALL carry the permutation input state x0..x4, sampled with start_i.
REQ-009 Port state_o  out  type_state  SHALL be the internal state register.
REQ-010 Port busy_o  out  1  SHALL be high while rounds are executing.
REQ-011 Port done_o  out  1  SHALL be a one-cycle pulse when the final round has been latched.

Function
REQ-012 The datapath SHALL compute one round per cycle in this order: Pc (constant addition), then the existing Ps substitution module (instantiated, not re-coded), then Pl (linear layer); the round result SHALL be registered into the state register.
REQ-013 Pc SHALL XOR the round constant into bits [7:0] of x2, where constant(r) = {4'hF - r[3:0], r[3:0]} for round index r in 0..11 (r = 0 gives 0xF0, r = 11 gives 0x4B).
REQ-014 A run SHALL start at r = 12 - N, where N is the selected round count; p^b therefore uses constants 0x96..0x4B.
REQ-015 Pl SHALL apply, with ror as 64-bit rotate-right:
- x0 ^= ror19 ^ ror28
- x1 ^= ror61 ^ ror39
- x2 ^= ror1 ^ ror6
- x3 ^= ror10 ^ ror17
- x4 ^= ror7 ^ ror41
REQ-016 The FSM SHALL have exactly two states:
- IDLE --start_i--> RUN
- RUN --(r == 11 latched)--> IDLE
REQ-017 In IDLE, start_i = 1 at edge E0 SHALL load state_i into the state register, load r = 12 - N, and set busy_o = 1.
REQ-018 Round k (k = 1..N) SHALL be latched at edge Ek.
REQ-019 At edge EN, busy_o SHALL fall, done_o SHALL rise for exactly one cycle, and the FSM SHALL return to IDLE.
REQ-020 Start-to-done latency SHALL be N cycles: done_o is high in the cycle following EN.
REQ-021 start_i SHALL be ignored while in RUN; the run in progress SHALL NOT be disturbed.
REQ-022 start_i high during the done_o cycle SHALL be accepted, allowing back-to-back runs with no idle gap.
REQ-023 state_o SHALL hold its value in IDLE until the next accepted start.
REQ-024 The round counter SHALL be 4 bits wide and SHALL NOT wrap past 11 within a run.

Reset
REQ-025 resetb_i = 0 SHALL immediately, without waiting for a clock edge, force: FSM = IDLE, r = 0, state register = 0, busy_o = 0, done_o = 0.
REQ-026 Reset asserted mid-run SHALL abort the run with no done_o pulse; after release the block SHALL accept a new start normally.

Verification
REQ-027 Reset check: assert resetb_i between clock edges -> state_o = 0, busy_o = 0, done_o = 0 with no edge required.
REQ-028 Substitution-vector check:
- stimulus: state_i = {80400c0600000000, 8a55114d1cb6a9a2, be263d4d7aecaa0f, 4ed0ec0b98c529b7, c8cddf37bcd0284a}, rounds_a_i = 1
- required: the Ps input at round 0 has x2 = be263d4d7aecaaff
- required: state_o after E1 equals Pl applied to the Ps unit-test output for that vector
REQ-029 Latency check: rounds_a_i = 1 -> done_o high exactly in the cycle after E12, busy_o high for 12 cycles; rounds_a_i = 0 -> done_o after E6.
REQ-030 Golden check: the same input with rounds_a_i = 1 and with rounds_a_i = 0 -> state_o equals the team C reference model p^12 and p^6 outputs, bit-exact.
REQ-031 Protocol check:
- start_i pulsed at E5 of a running p^a -> ignored; done_o still follows E12 with an unchanged result
- start_i held high through done_o -> the second run begins immediately with no idle gap
REQ-032 Mid-run reset check: resetb_i low after E3 -> no done_o, state_o = 0; a fresh start then completes with the golden result.
